spi_ram: RTL and testbench

Byte-wide single-port memory that sits directly downstream of the SPI slave. It decodes each 10-bit word the slave delivers on `rx_data`/`rx_valid`, where `rx_data[9:8]` is the command and `rx_data[7:0]` the payload, and executes one of four commands: write address, write data, read address, read data. Read results return to the slave on `tx_data`/`tx_valid` for shifting out on MISO. Write and read addresses auto-increment after each data access, so a master can burst without re-sending addresses.

---
 rtl/shared_pkg.sv | 15 +
 rtl/spi_ram_mem.sv | 38 +++
 rtl/spi_ram.sv | 117 +++++++++++
 tb/tb_spi_ram.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/shared_pkg.sv
// Shared definitions for the SPI slave datapath: command encoding and word widths
// carried on the rx_data/tx_data link between the SPI slave and its downstream RAM.
package shared_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } spi_cmd_e;

    localparam int SPI_WORD_W = 10;
    localparam int SPI_BYTE_W = 8;

endpackage

// File: rtl/spi_ram_mem.sv
// Byte storage array for spi_ram: one synchronous write port and one synchronous,
// enable-gated read port. Contents and read register are never reset.
module spi_ram_mem
    import shared_pkg::*;
#(
    parameter int MEM_DEPTH = 256
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(MEM_DEPTH)-1:0] waddr,
    input  logic [SPI_BYTE_W-1:0]        wdata,
    input  logic                         re,
    input  logic [$clog2(MEM_DEPTH)-1:0] raddr,
    output logic [SPI_BYTE_W-1:0]        rdata
);

    logic [SPI_BYTE_W-1:0] mem [MEM_DEPTH];
    logic [SPI_BYTE_W-1:0] rdata_q;
    logic [SPI_BYTE_W-1:0] rdata_d;

    // Read register only moves on an enabled read, so it holds the last byte fetched.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram.sv
// Command decoder sitting behind the SPI slave: latches write/read pointers,
// performs auto-incrementing byte accesses and returns read bytes on tx_data.
module spi_ram
    import shared_pkg::*;
#(
    parameter int MEM_DEPTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SPI_WORD_W-1:0] rx_data,
    input  logic                  rx_valid,
    output logic [SPI_BYTE_W-1:0] tx_data,
    output logic                  tx_valid,
    output logic                  cmd_err
);

    localparam int ADDR_SIZE = $clog2(MEM_DEPTH);

    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic                 wr_addr_ok_q, wr_addr_ok_d;
    logic                 rd_addr_ok_q, rd_addr_ok_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 cmd_err_q, cmd_err_d;
    logic                 have_rd_q, have_rd_d;

    spi_cmd_e              cmd;
    logic                  mem_we;
    logic                  mem_re;
    logic [SPI_BYTE_W-1:0] mem_rdata;

    assign cmd = spi_cmd_e'(rx_data[SPI_WORD_W-1:SPI_BYTE_W]);

    // A command coincident with rst is dropped, including its memory write.
    always_comb begin
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_ok_d = wr_addr_ok_q;
        rd_addr_ok_d = rd_addr_ok_q;
        have_rd_d    = have_rd_q;
        tx_valid_d   = 1'b0;
        cmd_err_d    = 1'b0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        if (rx_valid && !rst) begin
            unique case (cmd)
                CMD_WR_ADDR: begin
                    wr_addr_d    = rx_data[ADDR_SIZE-1:0];
                    wr_addr_ok_d = 1'b1;
                end
                CMD_WR_DATA: begin
                    if (wr_addr_ok_q) begin
                        mem_we    = 1'b1;
                        wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                CMD_RD_ADDR: begin
                    rd_addr_d    = rx_data[ADDR_SIZE-1:0];
                    rd_addr_ok_d = 1'b1;
                end
                CMD_RD_DATA: begin
                    if (rd_addr_ok_q) begin
                        mem_re     = 1'b1;
                        tx_valid_d = 1'b1;
                        have_rd_d  = 1'b1;
                        rd_addr_d  = rd_addr_q + ADDR_SIZE'(1);
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                default: begin
                    cmd_err_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            wr_addr_ok_q <= 1'b0;
            rd_addr_ok_q <= 1'b0;
            tx_valid_q   <= 1'b0;
            cmd_err_q    <= 1'b0;
            have_rd_q    <= 1'b0;
        end else begin
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_ok_q <= wr_addr_ok_d;
            rd_addr_ok_q <= rd_addr_ok_d;
            tx_valid_q   <= tx_valid_d;
            cmd_err_q    <= cmd_err_d;
            have_rd_q    <= have_rd_d;
        end
    end

    spi_ram_mem #(
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_addr_q),
        .wdata (rx_data[SPI_BYTE_W-1:0]),
        .re    (mem_re),
        .raddr (rd_addr_q),
        .rdata (mem_rdata)
    );

    // The unreset read register is masked until a read completes since the last reset.
    assign tx_data  = have_rd_q ? mem_rdata : '0;
    assign tx_valid = tx_valid_q;
    assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram.sv
// Self-checking bench for spi_ram: directed vector table, hand-written reset
// sequences, then randomized commands checked against a byte-array model.
module tb_spi_ram;

    logic       clk;
    logic       rst;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       cmd_err;

    int compared;
    int mismatched;

    spi_ram #(
        .MEM_DEPTH (256)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .cmd_err  (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [9:0] data;
        logic       exp_valid;
        logic       exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: memory with per-byte "written" tracking, plain int pointers.
    logic [7:0] m_mem   [256];
    bit         m_known [256];
    int         m_wr;
    int         m_rd;
    bit         m_wok;
    bit         m_rok;
    logic [7:0] m_data;
    bit         m_data_known;

    task automatic applyStimulus(input logic v, input logic [9:0] d);
        @(negedge clk);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic exp_valid, input logic exp_err,
                               input logic [7:0] exp_data, input bit chk_data);
        compared++;
        if (tx_valid !== exp_valid) begin
            mismatched++;
            $display("[TB] FAIL %s tx_valid got %0b want %0b", name, tx_valid, exp_valid);
        end
        compared++;
        if (cmd_err !== exp_err) begin
            mismatched++;
            $display("[TB] FAIL %s cmd_err got %0b want %0b", name, cmd_err, exp_err);
        end
        if (chk_data) begin
            compared++;
            if (tx_data !== exp_data) begin
                mismatched++;
                $display("[TB] FAIL %s tx_data got %02h want %02h", name, tx_data, exp_data);
            end
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic addVec(input logic v, input logic [9:0] d, input logic ev, input logic ee,
                          input logic [7:0] ed);
        vecs.push_back('{valid: v, data: d, exp_valid: ev, exp_err: ee, exp_data: ed});
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        rx_valid   = 1'b0;
        rx_data    = '0;

        // Directed vectors; every row is one cycle, so consecutive rows are back-to-back.
        addVec(1'b1, 10'h1_AA, 1'b0, 1'b1, 8'h00);
        addVec(1'b1, 10'h3_00, 1'b0, 1'b1, 8'h00);
        addVec(1'b0, 10'h3_00, 1'b0, 1'b0, 8'h00);
        addVec(1'b1, 10'h0_2A, 1'b0, 1'b0, 8'h00);
        addVec(1'b1, 10'h1_5C, 1'b0, 1'b0, 8'h00);
        addVec(1'b1, 10'h2_2A, 1'b0, 1'b0, 8'h00);
        addVec(1'b1, 10'h3_00, 1'b1, 1'b0, 8'h5C);
        addVec(1'b0, 10'h3_00, 1'b0, 1'b0, 8'h5C);
        addVec(1'b1, 10'h0_FE, 1'b0, 1'b0, 8'h5C);
        addVec(1'b1, 10'h1_11, 1'b0, 1'b0, 8'h5C);
        addVec(1'b1, 10'h1_22, 1'b0, 1'b0, 8'h5C);
        addVec(1'b1, 10'h1_33, 1'b0, 1'b0, 8'h5C);
        addVec(1'b1, 10'h2_FE, 1'b0, 1'b0, 8'h5C);
        addVec(1'b1, 10'h3_A5, 1'b1, 1'b0, 8'h11);
        addVec(1'b1, 10'h3_00, 1'b1, 1'b0, 8'h22);
        addVec(1'b1, 10'h3_00, 1'b1, 1'b0, 8'h33);
        addVec(1'b1, 10'h2_00, 1'b0, 1'b0, 8'h33);
        addVec(1'b1, 10'h3_00, 1'b1, 1'b0, 8'h33);
        addVec(1'b1, 10'h0_10, 1'b0, 1'b0, 8'h33);
        addVec(1'b1, 10'h1_77, 1'b0, 1'b0, 8'h33);
        addVec(1'b1, 10'h2_10, 1'b0, 1'b0, 8'h33);
        addVec(1'b1, 10'h3_00, 1'b1, 1'b0, 8'h77);
        addVec(1'b0, 10'h1_00, 1'b0, 1'b0, 8'h77);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 1'b0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].valid, vecs[i].data);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_err,
                        vecs[i].exp_data, 1'b1);
        end

        // Reset between two reads: pulse in flight clears at once, data survives.
        applyStimulus(1'b1, 10'h2_10);
        applyStimulus(1'b1, 10'h3_00);
        checkOutput("pre_rst_read", 1'b1, 1'b0, 8'h77, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("async_clear", 1'b0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 10'h3_00);
        checkOutput("rd_after_rst", 1'b0, 1'b1, 8'h00, 1'b1);
        applyStimulus(1'b1, 10'h2_10);
        applyStimulus(1'b1, 10'h3_00);
        checkOutput("preserved", 1'b1, 1'b0, 8'h77, 1'b1);

        // Command coincident with rst must be discarded.
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 10'h0_40;
        @(posedge clk);
        #1;
        checkOutput("rst_with_cmd", 1'b0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        rst      = 1'b0;
        rx_valid = 1'b0;
        applyStimulus(1'b1, 10'h1_99);
        checkOutput("addr_dropped", 1'b0, 1'b1, 8'h00, 1'b1);

        // Randomized commands against the model, with occasional resets.
        doReset();
        for (int a = 0; a < 256; a++) m_known[a] = 1'b0;
        m_wr = 0; m_rd = 0; m_wok = 1'b0; m_rok = 1'b0;
        m_data = 8'h00; m_data_known = 1'b1;
        for (int n = 0; n < 800; n++) begin
            logic       v;
            logic [1:0] c;
            int         payload;
            logic       ev;
            logic       ee;
            if ($urandom_range(0, 99) == 0) begin
                doReset();
                m_wr = 0; m_rd = 0; m_wok = 1'b0; m_rok = 1'b0;
                m_data = 8'h00; m_data_known = 1'b1;
            end
            v = ($urandom_range(0, 9) != 0);
            c = 2'($urandom_range(0, 3));
            if (c == 2'b00 || c == 2'b10) payload = (250 + $urandom_range(0, 15)) % 256;
            else payload = $urandom_range(0, 255);
            applyStimulus(v, {c, 8'(payload)});
            ev = 1'b0;
            ee = 1'b0;
            if (v) begin
                case (c)
                    2'b00: begin m_wr = payload; m_wok = 1'b1; end
                    2'b01: begin
                        if (m_wok) begin
                            m_mem[m_wr]   = 8'(payload);
                            m_known[m_wr] = 1'b1;
                            m_wr          = (m_wr + 1) % 256;
                        end else ee = 1'b1;
                    end
                    2'b10: begin m_rd = payload; m_rok = 1'b1; end
                    default: begin
                        if (m_rok) begin
                            ev           = 1'b1;
                            m_data       = m_mem[m_rd];
                            m_data_known = m_known[m_rd];
                            m_rd         = (m_rd + 1) % 256;
                        end else ee = 1'b1;
                    end
                endcase
            end
            checkOutput($sformatf("rand%0d", n), ev, ee, m_data, m_data_known);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
